dac_spi_driver: RTL and testbench

Serial output stage of the DDS chain: accepts 12-bit samples from the signal ROMs over a valid/ready handshake and shifts each one to an external 12-bit SPI DAC as one 16-bit frame. The frame is four zero control bits (normal power-down mode) followed by the sample, MSB first. It sits directly downstream of the square/sine/triangle ROM stage and drives the board pins SYNC, SCLK and DIN. The DAC latches SDATA on each falling SCLK edge and updates its output after the 16th falling edge.

---
 rtl/dac_spi_driver.sv | 159 +++++++++++++++
 tb/tb_dac_spi_driver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_driver.sv
// rtl/dac_spi_driver.sv - 16-bit SPI frame serializer for a 12-bit DAC
//
// Accepts one 12-bit sample per valid/ready handshake and shifts it out as
// {4'b0000, sample}, MSB first. The DAC latches sdata on each falling sclk.
//
// Parameters:
//   CLK_DIV   clk cycles per sclk half-period (>=1)
//   GAP_HALF  sclk half-periods that sync_n stays high between frames (>=1)
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sample[11:0]      DAC code from the ROM stage
//   sample_valid      sample is valid
//   sample_ready      registered; accept happens on valid && ready
//   sync_n            DAC frame sync, active-low
//   sclk              serial clock, idles high
//   sdata             serial data, MSB first
//   busy              high whenever the driver is not idle
//   frame_done        one-cycle pulse after a complete 16-bit frame
module dac_spi_driver #(
   parameter int CLK_DIV  = 2,
   parameter int GAP_HALF = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] sample,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        sync_n,
   output logic        sclk,
   output logic        sdata,
   output logic        busy,
   output logic        frame_done
);

   localparam int DW      = $clog2(CLK_DIV) + 1;
   localparam int GAP_LEN = GAP_HALF * CLK_DIV;
   localparam int GW      = $clog2(GAP_LEN) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t        state_q, state_d;
   logic [15:0]   shreg_q, shreg_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    bit_q, bit_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          sync_q, sync_d;
   logic          sclk_q, sclk_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // sdata comes straight from the shift register MSB, so it is registered
   // and changes only when the register shifts or is cleared.
   assign sdata        = shreg_q[15];
   assign sync_n       = sync_q;
   assign sclk         = sclk_q;
   assign sample_ready = ready_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         sync_q  <= 1'b1;
         sclk_q  <= 1'b1;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         sync_q  <= sync_d;
         sclk_q  <= sclk_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      div_d   = div_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      sync_d  = sync_q;
      sclk_d  = sclk_q;
      ready_d = ready_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            sync_d  = 1'b1;
            sclk_d  = 1'b1;
            shreg_d = '0;
            ready_d = 1'b1;
            if (sample_valid && ready_q) begin
               state_d = SHIFT;
               shreg_d = {4'b0000, sample};
               sync_d  = 1'b0;
               div_d   = '0;
               bit_d   = '0;
               ready_d = 1'b0;
            end
         end

         SHIFT: begin
            if (div_q == DW'(CLK_DIV - 1)) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               // A rising sclk (current level low) ends the current bit;
               // the falling edge is the DAC's sample point and leaves data alone.
               if (!sclk_q) begin
                  if (bit_q == 4'd15) begin
                     state_d = GAP;
                     sync_d  = 1'b1;
                     shreg_d = '0;
                     done_d  = 1'b1;
                     gap_d   = '0;
                  end else begin
                     bit_d   = bit_q + 4'd1;
                     shreg_d = {shreg_q[14:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end

         GAP: begin
            sclk_d = 1'b1;
            if (gap_q == GW'(GAP_LEN - 1)) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end

         default: begin
            state_d = IDLE;
            sync_d  = 1'b1;
            sclk_d  = 1'b1;
            shreg_d = '0;
            ready_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_dac_spi_driver.sv
// tb/tb_dac_spi_driver.sv - self-checking bench for dac_spi_driver
module tb_dac_spi_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] sample;
   logic        valid;
   logic        sel;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic valid_a, valid_b;
   logic ready_a, sync_a, sclk_a, sdata_a, busy_a, done_a;
   logic ready_b, sync_b, sclk_b, sdata_b, busy_b, done_b;
   assign valid_a = valid & ~sel;
   assign valid_b = valid & sel;

   dac_spi_driver #(.CLK_DIV(2), .GAP_HALF(2)) dut_a (
      .clk(clk), .rst(rst), .sample(sample), .sample_valid(valid_a),
      .sample_ready(ready_a), .sync_n(sync_a), .sclk(sclk_a), .sdata(sdata_a),
      .busy(busy_a), .frame_done(done_a));

   dac_spi_driver #(.CLK_DIV(1), .GAP_HALF(1)) dut_b (
      .clk(clk), .rst(rst), .sample(sample), .sample_valid(valid_b),
      .sample_ready(ready_b), .sync_n(sync_b), .sclk(sclk_b), .sdata(sdata_b),
      .busy(busy_b), .frame_done(done_b));

   logic m_ready, m_sync, m_sclk, m_sdata, m_busy, m_done;
   assign m_ready = sel ? ready_b : ready_a;
   assign m_sync  = sel ? sync_b  : sync_a;
   assign m_sclk  = sel ? sclk_b  : sclk_a;
   assign m_sdata = sel ? sdata_b : sdata_a;
   assign m_busy  = sel ? busy_b  : busy_a;
   assign m_done  = sel ? done_b  : done_a;

   // Reference frame: four zero control bits, then the 12-bit code.
   function automatic logic [15:0] ref_frame(input logic [11:0] s);
      return {4'b0000, s};
   endfunction

   // Called between a negedge and the following posedge; reports the
   // edge number on which the handshake completes.
   task automatic wait_accept(input int budget, output int a, output bit ok);
      ok = 1'b0;
      a  = -1;
      for (int i = 0; i < budget; i++) begin
         if (valid && m_ready) begin
            a  = cyc + 1;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Observes one frame from accept edge a until the expected return to idle,
   // acting as the DAC: shifts in sdata on every falling sclk while sync_n is low.
   task automatic capture(input int a, input int c, input int g,
                          output logic [15:0] word, output int nfall, output int mistime,
                          output int slow, output int ndone, output int done_at,
                          output int nbusy, output int ready_at);
      logic prev;
      prev = 1'b1; word = '0; nfall = 0; mistime = 0; slow = 0;
      ndone = 0; done_at = -1; nbusy = 0; ready_at = -1;
      for (int t = a; t <= a + (32 + g) * c; t++) begin
         @(negedge clk);
         if (!m_sync) slow++;
         if (prev && !m_sclk && !m_sync) begin
            word = {word[14:0], m_sdata};
            nfall++;
            if (cyc != a + (2 * nfall - 1) * c) mistime++;
         end
         prev = m_sclk;
         if (m_done) begin ndone++; done_at = cyc; end
         if (m_busy) nbusy++;
         if (m_ready && ready_at < 0) ready_at = cyc;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; valid = 1'b0; sample = '0; sel = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (m_sync !== 1'b1) begin failures++; $display("FAIL reset_sync got=%b exp=1", m_sync); end
      checks++; if (m_sclk !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b exp=1", m_sclk); end
      checks++; if (m_sdata !== 1'b0) begin failures++; $display("FAIL reset_sdata got=%b exp=0", m_sdata); end
      checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", m_busy); end
      checks++; if (m_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", m_done); end
      checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", m_ready); end
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", m_ready); end
      repeat (3) @(negedge clk);
      checks++; if ({m_sclk, m_sync, m_busy} !== 3'b110) begin failures++; $display("FAIL idle_pins got=%b exp=110", {m_sclk, m_sync, m_busy}); end
   endtask

   task automatic test_single_frame;
      int a, nfall, mistime, slow, ndone, done_at, nbusy, ready_at;
      bit ok;
      logic [15:0] word;
      #1 sample = 12'hA5C; valid = 1'b1;
      wait_accept(50, a, ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_accept got=timeout exp=accept"); valid = 1'b0; return; end
      fork
         capture(a, 2, 2, word, nfall, mistime, slow, ndone, done_at, nbusy, ready_at);
         begin @(posedge clk); #1 valid = 1'b0; sample = 12'($urandom); end
      join
      checks++; if (word !== ref_frame(12'hA5C)) begin failures++; $display("FAIL single_word got=%h exp=%h", word, ref_frame(12'hA5C)); end
      checks++; if (nfall !== 16) begin failures++; $display("FAIL single_nfall got=%0d exp=16", nfall); end
      checks++; if (mistime !== 0) begin failures++; $display("FAIL single_fall_timing got=%0d exp=0", mistime); end
      checks++; if (slow !== 64) begin failures++; $display("FAIL single_sync_low got=%0d exp=64", slow); end
      checks++; if (ndone !== 1 || done_at !== a + 64) begin failures++; $display("FAIL single_done got=%0d@%0d exp=1@%0d", ndone, done_at, a + 64); end
      checks++; if (nbusy !== 68) begin failures++; $display("FAIL single_busy got=%0d exp=68", nbusy); end
      checks++; if (ready_at !== a + 68) begin failures++; $display("FAIL single_ready got=%0d exp=%0d", ready_at, a + 68); end
   endtask

   task automatic test_back_to_back;
      logic [11:0] s [3];
      int a [3];
      int nfall, mistime, slow, ndone, done_at, nbusy, ready_at;
      bit ok;
      logic [15:0] word;
      s[0] = 12'h000; s[1] = 12'hFFF; s[2] = 12'h800;
      @(negedge clk); #1 sample = s[0]; valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_accept(200, a[i], ok);
         checks++; if (!ok) begin failures++; $display("FAIL b2b_accept%0d got=timeout exp=accept", i); valid = 1'b0; return; end
         if (i > 0) begin
            checks++; if (a[i] - a[i-1] !== 69) begin failures++; $display("FAIL b2b_period%0d got=%0d exp=69", i, a[i] - a[i-1]); end
            checks++; if (a[i] - (a[i-1] + 64) !== 5) begin failures++; $display("FAIL b2b_sync_high%0d got=%0d exp=5", i, a[i] - (a[i-1] + 64)); end
         end
         fork
            capture(a[i], 2, 2, word, nfall, mistime, slow, ndone, done_at, nbusy, ready_at);
            begin
               @(posedge clk); #1;
               if (i < 2) sample = s[i+1]; else valid = 1'b0;
            end
         join
         checks++; if (word !== ref_frame(s[i]) || nfall !== 16) begin failures++; $display("FAIL b2b_word%0d got=%h/%0d exp=%h/16", i, word, nfall, ref_frame(s[i])); end
      end
   endtask

   task automatic test_valid_toggle;
      logic [11:0] v0, v1;
      int a, nfall, mistime, slow, ndone, done_at, nbusy, ready_at;
      bit ok;
      logic [15:0] word;
      v0 = 12'($urandom); v1 = 12'($urandom);
      @(negedge clk); #1 sample = v0; valid = 1'b1;
      wait_accept(50, a, ok);
      checks++; if (!ok) begin failures++; $display("FAIL toggle_accept got=timeout exp=accept"); valid = 1'b0; return; end
      fork
         capture(a, 2, 2, word, nfall, mistime, slow, ndone, done_at, nbusy, ready_at);
         begin
            for (int i = 0; i < 40; i++) begin
               @(negedge clk); #1 valid = 1'($urandom); sample = 12'($urandom);
            end
            @(negedge clk); #1 valid = 1'b1; sample = v1;
         end
      join
      checks++; if (word !== ref_frame(v0) || nfall !== 16 || ndone !== 1) begin failures++; $display("FAIL toggle_first got=%h/%0d/%0d exp=%h/16/1", word, nfall, ndone, ref_frame(v0)); end
      wait_accept(10, a, ok);
      checks++; if (!ok) begin failures++; $display("FAIL toggle_accept2 got=timeout exp=accept"); valid = 1'b0; return; end
      fork
         capture(a, 2, 2, word, nfall, mistime, slow, ndone, done_at, nbusy, ready_at);
         begin @(posedge clk); #1 valid = 1'b0; sample = 12'($urandom); end
      join
      checks++; if (word !== ref_frame(v1) || nfall !== 16) begin failures++; $display("FAIL toggle_second got=%h/%0d exp=%h/16", word, nfall, ref_frame(v1)); end
   endtask

   task automatic test_reset_mid_frame;
      logic [11:0] v;
      int a, nfall, mistime, slow, ndone, done_at, nbusy, ready_at, dones;
      bit ok;
      logic [15:0] word;
      v = 12'($urandom);
      @(negedge clk); #1 sample = v; valid = 1'b1;
      wait_accept(50, a, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rstmid_accept got=timeout exp=accept"); valid = 1'b0; return; end
      @(posedge clk); #1 valid = 1'b0;
      // Bit 7 is on the line between the 8th and 9th falling edges.
      while (cyc < a + 16 * 2) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checks++; if ({m_sync, m_sclk, m_sdata, m_busy, m_ready} !== 5'b11000) begin failures++; $display("FAIL rstmid_pins got=%b exp=11000", {m_sync, m_sclk, m_sdata, m_busy, m_ready}); end
      dones = int'(m_done);
      repeat (3) begin @(negedge clk); dones += int'(m_done); end
      #1 rst = 1'b0;
      repeat (4) begin @(negedge clk); dones += int'(m_done); end
      checks++; if (dones !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
      v = 12'($urandom);
      #1 sample = v; valid = 1'b1;
      wait_accept(50, a, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rstmid_accept2 got=timeout exp=accept"); valid = 1'b0; return; end
      fork
         capture(a, 2, 2, word, nfall, mistime, slow, ndone, done_at, nbusy, ready_at);
         begin @(posedge clk); #1 valid = 1'b0; end
      join
      checks++; if (word !== ref_frame(v) || nfall !== 16 || mistime !== 0 || ndone !== 1) begin failures++; $display("FAIL rstmid_frame got=%h/%0d/%0d/%0d exp=%h/16/0/1", word, nfall, mistime, ndone, ref_frame(v)); end
   endtask

   task automatic test_random;
      logic [11:0] q [$];
      logic [11:0] v, e;
      int a, nfall, mistime, slow, ndone, done_at, nbusy, ready_at;
      bit ok;
      logic [15:0] word;
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         v = 12'($urandom);
         q.push_back(v);
         #1 sample = v; valid = 1'b1;
         wait_accept(50, a, ok);
         checks++; if (!ok) begin failures++; $display("FAIL rand_accept%0d got=timeout exp=accept", i); valid = 1'b0; return; end
         fork
            capture(a, 2, 2, word, nfall, mistime, slow, ndone, done_at, nbusy, ready_at);
            begin @(posedge clk); #1 valid = 1'b0; sample = 12'($urandom); end
         join
         e = q.pop_front();
         checks++; if (word !== ref_frame(e) || nfall !== 16 || mistime !== 0 || slow !== 64) begin failures++; $display("FAIL rand_frame%0d got=%h/%0d/%0d/%0d exp=%h/16/0/64", i, word, nfall, mistime, slow, ref_frame(e)); end
      end
   endtask

   task automatic test_fast_mode;
      logic [11:0] s [2];
      int a [2];
      int nfall, mistime, slow, ndone, done_at, nbusy, ready_at;
      bit ok;
      logic [15:0] word;
      s[0] = 12'h123; s[1] = 12'($urandom);
      @(negedge clk); #1 sel = 1'b1; sample = s[0]; valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         wait_accept(100, a[i], ok);
         checks++; if (!ok) begin failures++; $display("FAIL fast_accept%0d got=timeout exp=accept", i); valid = 1'b0; return; end
         if (i > 0) begin
            checks++; if (a[1] - a[0] !== 34) begin failures++; $display("FAIL fast_period got=%0d exp=34", a[1] - a[0]); end
         end
         fork
            capture(a[i], 1, 1, word, nfall, mistime, slow, ndone, done_at, nbusy, ready_at);
            begin @(posedge clk); #1; if (i == 0) sample = s[1]; else valid = 1'b0; end
         join
         checks++; if (word !== ref_frame(s[i]) || nfall !== 16 || mistime !== 0) begin failures++; $display("FAIL fast_frame%0d got=%h/%0d/%0d exp=%h/16/0", i, word, nfall, mistime, ref_frame(s[i])); end
         checks++; if (slow !== 32 || done_at !== a[i] + 32 || ready_at !== a[i] + 33) begin failures++; $display("FAIL fast_timing%0d got=%0d/%0d/%0d exp=32/%0d/%0d", i, slow, done_at, ready_at, a[i] + 32, a[i] + 33); end
      end
      @(negedge clk); #1 sel = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_single_frame;
      test_back_to_back;
      test_valid_toggle;
      test_reset_mid_frame;
      test_random;
      test_fast_mode;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
